// File: rtl/regfile_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_access_arbiter_if
//   Bundles every bus signal around the register-file arbiter: the two
//   requester channels, the tagged read-response channel, the register-file
//   drive/return signals and the init_done status.
//
//   Handshake rule for both requester channels: a request is transferred at
//   a rising clock edge where rN_valid and rN_ready are both 1. While
//   rN_valid=1 and rN_ready=0 the requester keeps every rN_* field stable.
//   The response channel has no ready: rsp_valid is a single-cycle pulse.
//
//   modport slave  : the arbiter side
//   modport master : the requesters / register-file side (the environment)
// ---------------------------------------------------------------------------
interface regfile_access_arbiter_if #(
   parameter int RAS = 2,
   parameter int MWS = 64
);
   // requester 0
   logic           r0_valid;
   logic           r0_ready;
   logic           r0_write;
   logic [RAS-1:0] r0_selA;
   logic [RAS-1:0] r0_selB;
   logic [MWS-1:0] r0_wdata;
   // requester 1
   logic           r1_valid;
   logic           r1_ready;
   logic           r1_write;
   logic [RAS-1:0] r1_selA;
   logic [RAS-1:0] r1_selB;
   logic [MWS-1:0] r1_wdata;
   // read response
   logic           rsp_valid;
   logic           rsp_id;
   logic [MWS-1:0] rsp_dataA;
   logic [MWS-1:0] rsp_dataB;
   // register file side
   logic [RAS-1:0] rf_selA;
   logic [RAS-1:0] rf_selB;
   logic [RAS-1:0] rf_selWrite;
   logic [MWS-1:0] rf_writeIn;
   logic           rf_isReading;
   logic [MWS-1:0] rf_outA;
   logic [MWS-1:0] rf_outB;
   // status
   logic           init_done;

   modport slave (
      input  r0_valid, r0_write, r0_selA, r0_selB, r0_wdata,
      output r0_ready,
      input  r1_valid, r1_write, r1_selA, r1_selB, r1_wdata,
      output r1_ready,
      output rsp_valid, rsp_id, rsp_dataA, rsp_dataB,
      output rf_selA, rf_selB, rf_selWrite, rf_writeIn, rf_isReading,
      input  rf_outA, rf_outB,
      output init_done
   );

   modport master (
      output r0_valid, r0_write, r0_selA, r0_selB, r0_wdata,
      input  r0_ready,
      output r1_valid, r1_write, r1_selA, r1_selB, r1_wdata,
      input  r1_ready,
      input  rsp_valid, rsp_id, rsp_dataA, rsp_dataB,
      input  rf_selA, rf_selB, rf_selWrite, rf_writeIn, rf_isReading,
      output rf_outA, rf_outB,
      input  init_done
   );
endinterface

// File: rtl/regfile_access_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_access_arbiter
//   Shares the register file's single operation slot (one dual read or one
//   write per clock) between two requesters with round-robin arbitration.
//   After every reset the block first writes zero to every register (CLEAR),
//   then serves traffic (RUN). Read data returns one cycle after acceptance,
//   tagged with the requester id; the register file is assumed to register
//   its outputs, so rsp_dataA/B are straight passthroughs of rf_outA/B.
//
// Ports
//   clk        : clock, all state changes on posedge
//   rst_n      : asynchronous active-low reset
//   bus        : requester, response and register-file signals (slave side)
//   dbg_state  : current FSM state (0 = CLEAR, 1 = RUN)
// ---------------------------------------------------------------------------
module regfile_access_arbiter #(
   parameter int REG_ADDRESS_SIZE = 2,
   parameter int NUM_REG          = 2**REG_ADDRESS_SIZE,
   parameter int MEM_WORD_SIZE    = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   regfile_access_arbiter_if.slave   bus,
   output logic                      dbg_state
);

   localparam logic [REG_ADDRESS_SIZE-1:0] LAST_PTR = REG_ADDRESS_SIZE'(NUM_REG - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                      state;
   state_t                      state_next;
   logic [REG_ADDRESS_SIZE-1:0] clr_ptr;
   logic                        last_grant;
   logic                        rsp_valid_q;
   logic                        rsp_id_q;

   logic                        grant_any;
   logic                        winner;
   logic                        req_write;
   logic [REG_ADDRESS_SIZE-1:0] req_selA;
   logic [REG_ADDRESS_SIZE-1:0] req_selB;
   logic [MEM_WORD_SIZE-1:0]    req_wdata;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= CLEAR;
         clr_ptr     <= '0;
         last_grant  <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
      end else begin
         state       <= state_next;
         if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
         end
         if (grant_any) begin
            last_grant <= winner;
         end
         rsp_valid_q <= grant_any & ~req_write;
         if (grant_any && !req_write) begin
            rsp_id_q <= winner;
         end
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_next = state;
      if (state == CLEAR && clr_ptr == LAST_PTR) begin
         state_next = RUN;
      end
   end

   // ---------------- arbitration ----------------
   // With both requesters valid the one not served last wins; with a single
   // valid requester it wins outright. rst_n gates the grant so ready drops
   // the moment reset is asserted, not at the next edge.
   always_comb begin
      grant_any = rst_n && (state == RUN) && (bus.r0_valid || bus.r1_valid);
      if (bus.r0_valid && bus.r1_valid) begin
         winner = ~last_grant;
      end else begin
         winner = bus.r1_valid;
      end
   end

   assign bus.r0_ready = grant_any & ~winner;
   assign bus.r1_ready = grant_any &  winner;

   always_comb begin
      if (winner) begin
         req_write = bus.r1_write;
         req_selA  = bus.r1_selA;
         req_selB  = bus.r1_selB;
         req_wdata = bus.r1_wdata;
      end else begin
         req_write = bus.r0_write;
         req_selA  = bus.r0_selA;
         req_selB  = bus.r0_selB;
         req_wdata = bus.r0_wdata;
      end
   end

   // ---------------- register-file drive ----------------
   // Idle is a harmless read of register 0, so only CLEAR or an accepted
   // write can ever drive rf_isReading low.
   always_comb begin
      bus.rf_isReading = 1'b1;
      bus.rf_selA      = '0;
      bus.rf_selB      = '0;
      bus.rf_selWrite  = '0;
      bus.rf_writeIn   = '0;
      if (rst_n) begin
         if (state == CLEAR) begin
            bus.rf_isReading = 1'b0;
            bus.rf_selWrite  = clr_ptr;
         end else if (grant_any) begin
            if (req_write) begin
               bus.rf_isReading = 1'b0;
               bus.rf_selWrite  = req_selA;
               bus.rf_writeIn   = req_wdata;
            end else begin
               bus.rf_selA = req_selA;
               bus.rf_selB = req_selB;
            end
         end
      end
   end

   // ---------------- response and status ----------------
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_dataA = bus.rf_outA;
   assign bus.rsp_dataB = bus.rf_outB;
   assign bus.init_done = (state == RUN);
   assign dbg_state     = state;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_access_arbiter
//   Drives two requesters against the arbiter, emulates a register file with
//   registered outputs and no reset (seeded with garbage so CLEAR matters),
//   and checks every cycle against a transaction-level model: an array of
//   register contents, a round-robin pointer and a queue of expected
//   responses. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_regfile_access_arbiter;

   localparam int RAS = 2;
   localparam int NR  = 4;
   localparam int MWS = 64;
   localparam int QW  = 1 + 2*MWS;

   logic clk = 1'b0;
   logic rst_n;
   logic dbg_state;

   regfile_access_arbiter_if #(.RAS(RAS), .MWS(MWS)) bus();

   regfile_access_arbiter #(
      .REG_ADDRESS_SIZE(RAS),
      .NUM_REG(NR),
      .MEM_WORD_SIZE(MWS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- register file emulation ----------------
   logic [MWS-1:0] rf_mem [NR];
   logic           rf_seeded = 1'b0;

   always @(posedge clk) begin
      if (!rf_seeded) begin
         for (int i = 0; i < NR; i++) rf_mem[i] <= {$urandom(), $urandom()} | 64'h1;
         rf_seeded <= 1'b1;
      end else if (bus.rf_isReading) begin
         bus.rf_outA <= rf_mem[bus.rf_selA];
         bus.rf_outB <= rf_mem[bus.rf_selB];
      end else begin
         rf_mem[bus.rf_selWrite] <= bus.rf_writeIn;
      end
   end

   // ---------------- scoreboard bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [MWS-1:0] act, input logic [MWS-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   logic [QW-1:0]  exp_q [$];
   logic [MWS-1:0] m_mem [NR];
   int             m_clr = 0;
   logic           m_last = 1'b1;

   always @(negedge clk) begin
      logic [QW-1:0]  e;
      logic           v0, v1, w, any, wr;
      logic [RAS-1:0] a, b;
      logic [MWS-1:0] d;
      if (!rst_n) begin
         chk("rst_ready0", bus.r0_ready, 0);
         chk("rst_ready1", bus.r1_ready, 0);
         chk("rst_isReading", bus.rf_isReading, 1);
         chk("rst_selA", bus.rf_selA, 0);
         chk("rst_selB", bus.rf_selB, 0);
         chk("rst_selWrite", bus.rf_selWrite, 0);
         chk("rst_writeIn", bus.rf_writeIn, 0);
         chk("rst_rsp_valid", bus.rsp_valid, 0);
         chk("rst_init_done", bus.init_done, 0);
         m_clr  = 0;
         m_last = 1'b1;
         exp_q.delete();
         for (int i = 0; i < NR; i++) m_mem[i] = '0;
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_id", bus.rsp_id, e[QW-1]);
            chk("rsp_dataA", bus.rsp_dataA, e[2*MWS-1:MWS]);
            chk("rsp_dataB", bus.rsp_dataB, e[MWS-1:0]);
         end else begin
            chk("rsp_idle", bus.rsp_valid, 0);
         end
         if (m_clr < NR) begin
            chk("clr_isReading", bus.rf_isReading, 0);
            chk("clr_selWrite", bus.rf_selWrite, 64'(m_clr));
            chk("clr_writeIn", bus.rf_writeIn, 0);
            chk("clr_ready0", bus.r0_ready, 0);
            chk("clr_ready1", bus.r1_ready, 0);
            chk("clr_init_done", bus.init_done, 0);
            m_clr++;
         end else begin
            chk("init_done", bus.init_done, 1);
            v0  = bus.r0_valid;
            v1  = bus.r1_valid;
            any = v0 | v1;
            if (v0 && v1) w = ~m_last;
            else          w = v1;
            chk("ready0", bus.r0_ready, 64'(any && !w));
            chk("ready1", bus.r1_ready, 64'(any && w));
            if (any) begin
               wr = w ? bus.r1_write : bus.r0_write;
               a  = w ? bus.r1_selA  : bus.r0_selA;
               b  = w ? bus.r1_selB  : bus.r0_selB;
               d  = w ? bus.r1_wdata : bus.r0_wdata;
               if (wr) begin
                  chk("wr_isReading", bus.rf_isReading, 0);
                  chk("wr_selWrite", bus.rf_selWrite, 64'(a));
                  chk("wr_writeIn", bus.rf_writeIn, d);
                  m_mem[a] = d;
               end else begin
                  chk("rd_isReading", bus.rf_isReading, 1);
                  chk("rd_selA", bus.rf_selA, 64'(a));
                  chk("rd_selB", bus.rf_selB, 64'(b));
                  exp_q.push_back({w, m_mem[a], m_mem[b]});
               end
               m_last = w;
            end else begin
               chk("idle_isReading", bus.rf_isReading, 1);
               chk("idle_selA", bus.rf_selA, 0);
               chk("idle_selB", bus.rf_selB, 0);
               chk("idle_writeIn", bus.rf_writeIn, 0);
            end
         end
      end
   end

   // ---------------- driver ----------------
   logic           s_ready0, s_ready1, s_rsp_valid, s_rsp_id, s_isr, s_init;
   logic [RAS-1:0] s_selw;
   logic [MWS-1:0] s_wr, s_rsp_a, s_rsp_b;
   logic           acc0, acc1;

   // Sample the current cycle at the falling edge, then step past the
   // next rising edge so new inputs can be applied.
   task automatic tick();
      @(negedge clk);
      s_ready0    = bus.r0_ready;
      s_ready1    = bus.r1_ready;
      s_rsp_valid = bus.rsp_valid;
      s_rsp_id    = bus.rsp_id;
      s_rsp_a     = bus.rsp_dataA;
      s_rsp_b     = bus.rsp_dataB;
      s_isr       = bus.rf_isReading;
      s_selw      = bus.rf_selWrite;
      s_wr        = bus.rf_writeIn;
      s_init      = bus.init_done;
      acc0        = bus.r0_valid & bus.r0_ready;
      acc1        = bus.r1_valid & bus.r1_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic set_r0(input logic v, input logic wr, input logic [RAS-1:0] a,
                         input logic [RAS-1:0] b, input logic [MWS-1:0] d);
      bus.r0_valid = v; bus.r0_write = wr; bus.r0_selA = a; bus.r0_selB = b; bus.r0_wdata = d;
   endtask

   task automatic set_r1(input logic v, input logic wr, input logic [RAS-1:0] a,
                         input logic [RAS-1:0] b, input logic [MWS-1:0] d);
      bus.r1_valid = v; bus.r1_write = wr; bus.r1_selA = a; bus.r1_selB = b; bus.r1_wdata = d;
   endtask

   // New random request only once the previous one was taken or absent.
   task automatic drive_random();
      if (!(bus.r0_valid && !acc0))
         set_r0($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), {$urandom(), $urandom()});
      if (!(bus.r1_valid && !acc1))
         set_r1($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), {$urandom(), $urandom()});
   endtask

   task automatic check_clear_sequence(input string tag);
      for (int i = 0; i < NR; i++) begin
         tick();
         chk({tag, "_isReading"}, s_isr, 0);
         chk({tag, "_selWrite"}, s_selw, 64'(i));
         chk({tag, "_writeIn"}, s_wr, 0);
         chk({tag, "_ready0"}, s_ready0, 0);
         chk({tag, "_init"}, s_init, 0);
      end
      tick();
      chk({tag, "_init_done_cycle5"}, s_init, 1);
   endtask

   logic [MWS-1:0] rb_exp [NR];

   initial begin
      rst_n = 1'b0;
      set_r0(0, 0, 0, 0, 0);
      set_r1(0, 0, 0, 0, 0);
      acc0 = 0; acc1 = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Test 1: CLEAR walk after reset release
      check_clear_sequence("t1");

      // Test 5: idle cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_isReading", s_isr, 1);
         chk("t5_ready0", s_ready0, 0);
         chk("t5_ready1", s_ready1, 0);
         chk("t5_rsp_valid", s_rsp_valid, 0);
      end

      // Test 3: both read for 6 cycles, grants alternate starting at 0
      set_r0(1, 0, 1, 2, 0);
      set_r1(1, 0, 3, 0, 0);
      for (int i = 0; i < 7; i++) begin
         if (i == 6) begin
            bus.r0_valid = 0;
            bus.r1_valid = 0;
         end
         tick();
         if (i < 6) begin
            chk("t3_ready0", s_ready0, 64'(i % 2 == 0));
            chk("t3_ready1", s_ready1, 64'(i % 2 == 1));
         end
         if (i > 0) begin
            chk("t3_rsp_valid", s_rsp_valid, 1);
            chk("t3_rsp_id", s_rsp_id, 64'((i - 1) % 2));
         end
      end

      // Test 4: r1 write reg3=5 and r0 read reg3 together, last_grant=1
      set_r0(1, 0, 3, 3, 0);
      set_r1(1, 1, 3, 0, 64'd5);
      tick();
      chk("t4_first_ready0", s_ready0, 1);
      chk("t4_first_ready1", s_ready1, 0);
      tick();
      chk("t4_second_ready1", s_ready1, 1);
      chk("t4_old_rsp_valid", s_rsp_valid, 1);
      chk("t4_old_dataA", s_rsp_a, 0);
      bus.r1_valid = 0;
      tick();
      chk("t4_third_ready0", s_ready0, 1);
      chk("t4_gap_rsp_valid", s_rsp_valid, 0);
      bus.r0_valid = 0;
      tick();
      chk("t4_new_rsp_valid", s_rsp_valid, 1);
      chk("t4_new_dataA", s_rsp_a, 64'd5);
      chk("t4_new_id", s_rsp_id, 0);

      // Test 2: r0 write reg2=DEAD then read A=2 B=0
      set_r0(1, 1, 2, 0, 64'hDEAD);
      tick();
      chk("t2_wr_ready0", s_ready0, 1);
      set_r0(1, 0, 2, 0, 0);
      tick();
      chk("t2_rd_ready0", s_ready0, 1);
      bus.r0_valid = 0;
      tick();
      chk("t2_rsp_valid", s_rsp_valid, 1);
      chk("t2_rsp_id", s_rsp_id, 0);
      chk("t2_dataA", s_rsp_a, 64'hDEAD);
      chk("t2_dataB", s_rsp_b, 0);

      // Test 5 read-back: contents unchanged by idle cycles
      rb_exp[0] = 0; rb_exp[1] = 0; rb_exp[2] = 64'hDEAD; rb_exp[3] = 64'd5;
      repeat (3) tick();
      for (int r = 0; r <= NR; r++) begin
         if (r < NR) set_r0(1, 0, 2'(r), 2'(r), 0);
         else        bus.r0_valid = 0;
         tick();
         if (r > 0) begin
            chk("t5_rb_dataA", s_rsp_a, rb_exp[r-1]);
            chk("t5_rb_dataB", s_rsp_b, rb_exp[r-1]);
         end
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive_random();
         tick();
      end
      bus.r0_valid = 0;
      bus.r1_valid = 0;
      repeat (3) tick();

      // Test 6: reset the cycle after a read accept
      set_r0(1, 0, 1, 2, 0);
      tick();
      chk("t6_rsp_before_rst", bus.rsp_valid, 1);
      chk("t6_ready_before_rst", bus.r0_ready, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_ready0", bus.r0_ready, 0);
      chk("t6_async_rsp_valid", bus.rsp_valid, 0);
      chk("t6_async_isReading", bus.rf_isReading, 1);
      chk("t6_async_init_done", bus.init_done, 0);
      bus.r0_valid = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      check_clear_sequence("t6");

      for (int i = 0; i < 200; i++) begin
         drive_random();
         tick();
      end
      bus.r0_valid = 0;
      bus.r1_valid = 0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
